// File: rtl/wishbone_spi_slave.sv
// Wishbone-attached SPI mode-0 slave: 8-bit frames, RX FIFO, single-byte TX holding register,
// sticky overrun/underrun flags and a level interrupt.
module wishbone_spi_slave #(
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  i_wb_adr,
   input  logic [31:0] i_wb_dat,
   output logic [31:0] o_wb_dat,
   input  logic        i_wb_we,
   input  logic        i_wb_stb,
   input  logic        i_wb_cyc,
   output logic        o_wb_ack,
   output logic        o_wb_err,
   output logic        o_wb_rty,
   input  logic        i_spi_sclk,
   input  logic        i_spi_cs_n,
   input  logic        i_spi_mosi,
   output logic        o_spi_miso,
   output logic        o_spi_miso_oe,
   output logic        o_int
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);

   logic          sclk_s1, sclk_s2, sclk_s3;
   logic          cs_s1, cs_s2, cs_s3;
   logic          mosi_s1, mosi_s2;
   logic [2:0]    bit_cnt;
   logic [7:0]    rx_shift, tx_shift;
   logic [7:0]    hold_data;
   logic          hold_full;
   logic [7:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [4:0]    count;
   logic          overrun, underrun;
   logic [2:0]    ctrl;

   logic          cs_active, cs_fall, cs_rise, sclk_rise, sclk_fall;
   logic          tx_load, push_req, push_ok, pop;
   logic          rx_empty, rx_full;
   logic          wb_req, wb_wr, wb_rd, stat_wr;
   logic [7:0]    rx_byte;
   logic [31:0]   rdata;
   logic          wdat_unused;

   assign cs_active = ~cs_s2;
   assign cs_fall   = cs_s3 & ~cs_s2;
   assign cs_rise   = ~cs_s3 & cs_s2;
   assign sclk_rise = sclk_s2 & ~sclk_s3 & cs_active & ~cs_fall;
   assign sclk_fall = ~sclk_s2 & sclk_s3 & cs_active & ~cs_fall;

   // A falling edge with bit_cnt == 0 follows a completed byte: fetch the next TX byte.
   assign tx_load  = cs_fall | (sclk_fall & (bit_cnt == 3'd0));
   assign rx_byte  = {rx_shift[6:0], mosi_s2};
   assign push_req = sclk_rise & (bit_cnt == 3'd7);

   assign rx_empty = (count == 5'd0);
   assign rx_full  = (count == 5'(FIFO_DEPTH));

   assign wb_req  = i_wb_stb & i_wb_cyc & ~o_wb_ack;
   assign wb_wr   = wb_req & i_wb_we;
   assign wb_rd   = wb_req & ~i_wb_we;
   assign stat_wr = wb_wr & (i_wb_adr == 2'd1);
   assign pop     = wb_rd & (i_wb_adr == 2'd0) & ~rx_empty;
   assign push_ok = push_req & (~rx_full | pop);

   assign wdat_unused = ^{i_wb_dat[31:13], i_wb_dat[10:8]};

   always_comb begin
      rdata = 32'd0;
      case (i_wb_adr)
         2'd0: rdata = rx_empty ? 32'd0 : {24'd0, mem[rd_ptr]};
         2'd1: rdata = {18'd0, cs_active, underrun, overrun, ~hold_full, rx_full, rx_empty,
                        3'd0, count};
         2'd2: rdata = {29'd0, ctrl};
         default: rdata = 32'd0;
      endcase
   end

   // FIFO storage needs no reset; pointers and count qualify its contents.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= rx_byte;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sclk_s1   <= 1'b0;
         sclk_s2   <= 1'b0;
         sclk_s3   <= 1'b0;
         cs_s1     <= 1'b1;
         cs_s2     <= 1'b1;
         cs_s3     <= 1'b1;
         mosi_s1   <= 1'b0;
         mosi_s2   <= 1'b0;
         bit_cnt   <= 3'd0;
         rx_shift  <= 8'd0;
         tx_shift  <= 8'd0;
         hold_data <= 8'd0;
         hold_full <= 1'b0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= 5'd0;
         overrun   <= 1'b0;
         underrun  <= 1'b0;
         ctrl      <= 3'd0;
         o_wb_ack  <= 1'b0;
         o_wb_dat  <= 32'd0;
      end else begin
         sclk_s1 <= i_spi_sclk;
         sclk_s2 <= sclk_s1;
         sclk_s3 <= sclk_s2;
         cs_s1   <= i_spi_cs_n;
         cs_s2   <= cs_s1;
         cs_s3   <= cs_s2;
         mosi_s1 <= i_spi_mosi;
         mosi_s2 <= mosi_s1;

         if (cs_fall || cs_rise) bit_cnt <= 3'd0;
         else if (sclk_rise)     bit_cnt <= bit_cnt + 3'd1;

         if (sclk_rise) rx_shift <= rx_byte;

         // The shifter takes the old holding byte even when a DATA write lands this cycle.
         if (tx_load)        tx_shift <= hold_full ? hold_data : 8'd0;
         else if (sclk_fall) tx_shift <= {tx_shift[6:0], 1'b0};

         if (wb_wr && (i_wb_adr == 2'd0)) begin
            hold_data <= i_wb_dat[7:0];
            hold_full <= 1'b1;
         end else if (tx_load) begin
            hold_full <= 1'b0;
         end

         if (push_ok) wr_ptr <= wr_ptr + AW'(1);
         if (pop)     rd_ptr <= rd_ptr + AW'(1);
         if (push_ok && !pop)      count <= count + 5'd1;
         else if (pop && !push_ok) count <= count - 5'd1;

         overrun  <= (push_req & rx_full & ~pop) | (overrun & ~(stat_wr & i_wb_dat[11]));
         underrun <= (tx_load & ~hold_full) | (underrun & ~(stat_wr & i_wb_dat[12]));

         if (wb_wr && (i_wb_adr == 2'd2)) ctrl <= i_wb_dat[2:0];

         o_wb_ack <= wb_req;
         o_wb_dat <= wb_rd ? rdata : 32'd0;
      end
   end

   assign o_wb_err      = 1'b0;
   assign o_wb_rty      = 1'b0;
   assign o_spi_miso    = cs_active & tx_shift[7];
   assign o_spi_miso_oe = cs_active;
   assign o_int = (ctrl[0] & ~rx_empty) | (ctrl[1] & ~hold_full) | (ctrl[2] & (overrun | underrun));

endmodule
